output_neuron_backprop: RTL and testbench
=========================================

// Module: output_neuron_backprop
// PURPOSE
//  Backward-pass companion to the output neuron. Takes a finished forward result and its
//  target, forms the error, computes per-weight gradients on one shared multiplier and
//  writes back updated weights w0/w1. Sits between the forward neuron and the weight store;
//  the forward neuron consumes w0_o/w1_o.
// PARAMETERS
//  FRAC_W    7   fractional bits of weights (1.7 format); target is aligned by << FRAC_W
//  LR_SHIFT  2   learning rate = 2^-LR_SHIFT, applied as extra arithmetic right shift
//  W0_INIT   64  reset value of w0_o (0.5 in 1.7)
//  W1_INIT   64  reset value of w1_o
// PORTS
//  clk_i        in   1   clock
//  rst_i        in   1   reset, asynchronous, active-low
//  en_i         in   1   global enable; low = FSM and all registers hold
//  start_i      in   1   start update; sampled only in IDLE with en_i high
//  wload_i      in   1   load w0_i/w1_i into weight regs; IDLE only, priority over start_i
//  w0_i, w1_i   in   8   weights to load (unsigned 1.7)
//  target_i     in   4   unsigned integer target
//  predicted_i  in   21  unsigned forward result (FRAC_W fractional bits)
//  x0_i, x1_i   in   10  unsigned neuron inputs used in the forward pass
//  w0_o, w1_o   out  8   current weights (registered)
//  err_o        out  22  signed error of last update (registered)
//  busy_o       out  1   high in every state except IDLE
//  done_o       out  1   one-cycle pulse when weights written
// BEHAVIOUR
//  Reset: state=IDLE, w0_o=W0_INIT, w1_o=W1_INIT, err_o=0, busy_o=0, done_o=0; asserting
//   rst_i mid-update aborts it, no partial write survives.
//  States: IDLE -> ERR -> MUL0 -> MUL1 -> UPD -> IDLE. Each advance needs en_i high.
//   IDLE: wload_i -> weights <= w*_i (no done_o). else start_i -> capture target_i,
//     predicted_i, x0_i, x1_i; go ERR. start_i/wload_i outside IDLE ignored.
//   ERR : err = $signed({target,FRAC_W zeros}) - $signed({1'b0,predicted}), 22-bit signed;
//     latch into err_o.
//   MUL0: d0 = (err * $signed({1'b0,x0})) >>> (FRAC_W+LR_SHIFT); 33-bit product, arithmetic
//     shift (rounds toward -inf). MUL1: same for d1 with x1 on the shared multiplier.
//   UPD : w_k <= clamp/wrap(w_k + d_k), computed in 34-bit signed; pulse done_o; go IDLE.
//  Latency: start sampled at edge N -> weights and done_o visible after edge N+4.
//  err=0 or x_k=0 -> w_k unchanged. en_i low mid-update freezes state, done_o held low.
//  done_o is a pulse; if en_i low in UPD the pulse is issued only when UPD completes.
// CONFIGURATION
//  WEIGHT_SAT_EN defined: update result saturates to [0,255].
//  WEIGHT_SAT_EN undefined: update result wraps modulo 256 (low 8 bits kept).
// STRUCTURE
//  nn_pkg: FRAC_W default, widths (X_W=10, W_W=8, PRED_W=21, ERR_W=22), state enum
//   bp_state_t {IDLE,ERR,MUL0,MUL1,UPD}. Shared with forward neuron and loss calc.
//  Sub-module weight_clamp: 34-bit signed sum in, 8-bit weight out; holds the
//   WEIGHT_SAT_EN ifdef. Multiplier stays inline (single shared instance).
// TESTING
//  Reset: rst_i low mid-MUL0 -> state IDLE, w0_o=w1_o=64, done_o=0, busy_o=0.
//  Small positive: w0=64,target=3,pred=256,x0=4,x1=0 -> err_o=128, w0_o=65, w1_o=64,
//   done_o after 5th edge.
//  Negative underflow: wload w0=10; target=0,pred=1024,x0=8 -> err=-1024, d0=-16;
//   SAT: w0_o=0; no SAT: w0_o=250.
//  Positive overflow: wload w0=200; target=15,pred=0,x0=1023 -> err=1920, d0=3836;
//   SAT: w0_o=255; no SAT: w0_o=196.
//  Handshake: start_i held during busy, wload_i in MUL1 -> ignored, one done_o only;
//   en_i low 3 cycles in MUL0 -> done_o delayed exactly 3 cycles.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared neuron package: fixed-point widths and the backprop FSM state encoding.
package nn_pkg;
  localparam int FRAC_W = 7;
  localparam int X_W    = 10;
  localparam int W_W    = 8;
  localparam int T_W    = 4;
  localparam int PRED_W = 21;
  localparam int ERR_W  = 22;
  localparam int PROD_W = ERR_W + X_W + 1;
  localparam int SUM_W  = PROD_W + 1;

  typedef enum logic [2:0] {IDLE, ERR, MUL0, MUL1, UPD} bp_state_t;

  typedef struct packed {
    logic [T_W-1:0]    target;
    logic [PRED_W-1:0] pred;
    logic [X_W-1:0]    x0;
    logic [X_W-1:0]    x1;
  } bp_req_t;
endpackage

// File: rtl/output_neuron_backprop_if.sv
// Control/data bundle between the backprop block, the forward neuron and the weight store.
interface output_neuron_backprop_if;
  logic                              en_i, start_i, wload_i;
  logic [nn_pkg::W_W-1:0]            w0_i, w1_i;
  logic [nn_pkg::T_W-1:0]            target_i;
  logic [nn_pkg::PRED_W-1:0]         predicted_i;
  logic [nn_pkg::X_W-1:0]            x0_i, x1_i;
  logic [nn_pkg::W_W-1:0]            w0_o, w1_o;
  logic signed [nn_pkg::ERR_W-1:0]   err_o;
  logic                              busy_o, done_o;

  modport slave (input en_i, start_i, wload_i, w0_i, w1_i, target_i, predicted_i, x0_i, x1_i,
                 output w0_o, w1_o, err_o, busy_o, done_o);
  modport master (output en_i, start_i, wload_i, w0_i, w1_i, target_i, predicted_i, x0_i, x1_i,
                  input w0_o, w1_o, err_o, busy_o, done_o);
endinterface

// File: rtl/weight_clamp.sv
// Maps a wide signed update sum onto an 8-bit weight.
// WEIGHT_SAT_EN defined: saturate to [0,255]; undefined: wrap modulo 256.
module weight_clamp
  import nn_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum_i,
  output logic [W_W-1:0]          w_o
);
`ifdef WEIGHT_SAT_EN
  localparam logic signed [SUM_W-1:0] WMAX = SUM_W'((1 << W_W) - 1);
  always_comb begin
    w_o = sum_i[W_W-1:0];
    if (sum_i < 0)         w_o = '0;
    else if (sum_i > WMAX) w_o = '1;
  end
`else
  logic unused_hi;
  assign unused_hi = ^sum_i[SUM_W-1:W_W];
  assign w_o = sum_i[W_W-1:0];
`endif
endmodule

// File: rtl/output_neuron_backprop.sv
// Backward pass for the output neuron: error, two gradients on one multiplier, weight update.
// Update arithmetic saturates when WEIGHT_SAT_EN is defined, otherwise wraps.
module output_neuron_backprop
  import nn_pkg::*;
#(
  parameter int FRAC_W   = nn_pkg::FRAC_W,
  parameter int LR_SHIFT = 2,
  parameter logic [W_W-1:0] W0_INIT = 8'd64,
  parameter logic [W_W-1:0] W1_INIT = 8'd64
) (
  input logic clk_i,
  input logic rst_i,
  output_neuron_backprop_if.slave bus
);
  bp_state_t state_q, state_d;
  bp_req_t   req_q;
  logic signed [ERR_W-1:0]  err_q, err_d;
  logic signed [PROD_W-1:0] d0_q, d1_q, prod, d_cur;
  logic signed [SUM_W-1:0]  sum0, sum1;
  logic [W_W-1:0] w0_q, w1_q, w0_new, w1_new;
  logic [X_W-1:0] x_sel;
  logic done_q;

  always_comb begin
    state_d = state_q;
    if (bus.en_i) begin
      unique case (state_q)
        IDLE:    if (!bus.wload_i && bus.start_i) state_d = ERR;
        ERR:     state_d = MUL0;
        MUL0:    state_d = MUL1;
        MUL1:    state_d = UPD;
        UPD:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign err_d = $signed({{(ERR_W-T_W-FRAC_W){1'b0}}, req_q.target, {FRAC_W{1'b0}}})
               - $signed({1'b0, req_q.pred});

  // single shared multiplier; operand chosen by which gradient is being formed
  assign x_sel = (state_q == MUL1) ? req_q.x1 : req_q.x0;
  assign prod  = $signed({{(PROD_W-ERR_W){err_q[ERR_W-1]}}, err_q})
               * $signed({{(PROD_W-X_W){1'b0}}, x_sel});
  assign d_cur = prod >>> (FRAC_W + LR_SHIFT);

  assign sum0 = $signed({{(SUM_W-W_W){1'b0}}, w0_q}) + $signed({d0_q[PROD_W-1], d0_q});
  assign sum1 = $signed({{(SUM_W-W_W){1'b0}}, w1_q}) + $signed({d1_q[PROD_W-1], d1_q});

  weight_clamp u_clamp0 (.sum_i(sum0), .w_o(w0_new));
  weight_clamp u_clamp1 (.sum_i(sum1), .w_o(w1_new));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      w0_q    <= W0_INIT;
      w1_q    <= W1_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= bus.en_i && (state_q == UPD);
      if (bus.en_i) begin
        unique case (state_q)
          IDLE: begin
            if (bus.wload_i) begin
              w0_q <= bus.w0_i;
              w1_q <= bus.w1_i;
            end else if (bus.start_i) begin
              req_q <= '{target: bus.target_i, pred: bus.predicted_i, x0: bus.x0_i, x1: bus.x1_i};
            end
          end
          ERR:  err_q <= err_d;
          MUL0: d0_q  <= d_cur;
          MUL1: d1_q  <= d_cur;
          UPD: begin
            w0_q <= w0_new;
            w1_q <= w1_new;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.w0_o   = w0_q;
  assign bus.w1_o   = w1_q;
  assign bus.err_o  = err_q;
  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_output_neuron_backprop.sv
// Directed bench with a transaction-level reference model checked every cycle.
module tb_output_neuron_backprop;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  output_neuron_backprop_if bus ();

  output_neuron_backprop dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  int nassert = 0;
  int nfail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: whole-update result from plain integer arithmetic
  function automatic longint f_err(input int t, input int p);
    return longint'(t) * 128 - longint'(p);
  endfunction

  function automatic logic [7:0] f_upd(input int w, input longint e, input int x);
    longint d, s;
    d = (e * longint'(x)) >>> 9;
    s = longint'(w) + d;
`ifdef WEIGHT_SAT_EN
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
`endif
    return 8'(s & 255);
  endfunction

  // model tracks only how many enabled cycles remain in an update
  int rem;
  logic [7:0] mw0, mw1, nw0, nw1;
  longint merr, perr;
  logic mdone;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rem <= 0; mw0 <= 8'd64; mw1 <= 8'd64; merr <= 0; perr <= 0; mdone <= 1'b0;
      nw0 <= 8'd64; nw1 <= 8'd64;
    end else begin
      mdone <= 1'b0;
      if (bus.en_i) begin
        if (rem == 0) begin
          if (bus.wload_i) begin
            mw0 <= bus.w0_i; mw1 <= bus.w1_i;
          end else if (bus.start_i) begin
            perr <= f_err(bus.target_i, bus.predicted_i);
            nw0  <= f_upd(mw0, f_err(bus.target_i, bus.predicted_i), bus.x0_i);
            nw1  <= f_upd(mw1, f_err(bus.target_i, bus.predicted_i), bus.x1_i);
            rem  <= 4;
          end
        end else begin
          rem <= rem - 1;
          if (rem == 4) merr <= perr;
          if (rem == 1) begin
            mw0 <= nw0; mw1 <= nw1; mdone <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk_i) begin
    check("model_w0", bus.w0_o, mw0);
    check("model_w1", bus.w1_o, mw1);
    check("model_err", bus.err_o, merr);
    check("model_busy", bus.busy_o, rem != 0);
    check("model_done", bus.done_o, mdone);
  end

  task automatic wload(input int a, input int b);
    @(negedge clk_i);
    bus.wload_i = 1'b1; bus.w0_i = 8'(a); bus.w1_i = 8'(b);
    @(negedge clk_i);
    bus.wload_i = 1'b0;
    check("wload_w0", bus.w0_o, a);
    check("wload_w1", bus.w1_o, b);
  endtask

  // runs one update; en_i dropped for cycles [off_at, on_at) counted in negedges after start
  task automatic run_op(input int t, input int p, input int x0, input int x1,
                        input int off_at, input int on_at, output int lat);
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.target_i = 4'(t); bus.predicted_i = 21'(p);
    bus.x0_i = 10'(x0); bus.x1_i = 10'(x1);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
      bus.start_i = 1'b0;
      if (lat == off_at) bus.en_i = 1'b0;
      if (lat == on_at)  bus.en_i = 1'b1;
    end while (!bus.done_o && lat < 40);
    bus.en_i = 1'b1;
    if (!bus.done_o) check("done_timeout", 0, 1);
  endtask

  int lat, ndone;

  initial begin
    bus.en_i = 1'b1; bus.start_i = 1'b0; bus.wload_i = 1'b0;
    bus.w0_i = '0; bus.w1_i = '0; bus.target_i = '0; bus.predicted_i = '0;
    bus.x0_i = '0; bus.x1_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_w0", bus.w0_o, 64);
    check("rst_w1", bus.w1_o, 64);
    check("rst_err", bus.err_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    rst_i = 1'b1;

    // reset aborts an update in MUL0
    wload(100, 120);
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.target_i = 4'd3; bus.predicted_i = 21'd256; bus.x0_i = 10'd4;
    @(negedge clk_i); bus.start_i = 1'b0;
    @(negedge clk_i);
    check("mid_busy", bus.busy_o, 1);
    #1 rst_i = 1'b0;
    #1;
    check("abort_w0", bus.w0_o, 64);
    check("abort_w1", bus.w1_o, 64);
    check("abort_busy", bus.busy_o, 0);
    check("abort_done", bus.done_o, 0);
    @(negedge clk_i);
    #1 rst_i = 1'b1;

    // small positive
    run_op(3, 256, 4, 0, -1, -1, lat);
    check("sp_lat", lat, 5);
    check("sp_err", bus.err_o, 128);
    check("sp_w0", bus.w0_o, 65);
    check("sp_w1", bus.w1_o, 64);

    // negative underflow
    wload(10, 64);
    run_op(0, 1024, 8, 0, -1, -1, lat);
    check("neg_err", bus.err_o, -1024);
`ifdef WEIGHT_SAT_EN
    check("neg_w0", bus.w0_o, 0);
`else
    check("neg_w0", bus.w0_o, 250);
`endif

    // positive overflow
    wload(200, 64);
    run_op(15, 0, 1023, 0, -1, -1, lat);
    check("pos_err", bus.err_o, 1920);
`ifdef WEIGHT_SAT_EN
    check("pos_w0", bus.w0_o, 255);
`else
    check("pos_w0", bus.w0_o, 196);
`endif

    // both gradients nonzero
    wload(64, 64);
    run_op(5, 300, 7, 900, -1, -1, lat);
    check("two_err", bus.err_o, 340);
    check("two_w0", bus.w0_o, 68);
`ifdef WEIGHT_SAT_EN
    check("two_w1", bus.w1_o, 255);
`else
    check("two_w1", bus.w1_o, 149);
`endif

    // zero error leaves weights alone
    run_op(2, 256, 500, 500, -1, -1, lat);
    check("zero_err", bus.err_o, 0);
    check("zero_w0", bus.w0_o, 68);

    // start held through busy, wload in MUL1 ignored, single done
    wload(64, 64);
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.target_i = 4'd1; bus.predicted_i = 21'd0;
    bus.x0_i = 10'd100; bus.x1_i = 10'd50;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
      if (lat == 3) begin bus.wload_i = 1'b1; bus.w0_i = 8'd0; bus.w1_i = 8'd0; end
      if (lat == 4) bus.wload_i = 1'b0;
    end while (!bus.done_o && lat < 40);
    bus.start_i = 1'b0;
    check("hs_lat", lat, 5);
    check("hs_w0", bus.w0_o, 89);
    check("hs_w1", bus.w1_o, 76);
    ndone = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (bus.done_o) ndone++;
    end
    check("hs_extra_done", ndone, 0);

    // en_i low 3 cycles in MUL0
    run_op(3, 256, 4, 0, 2, 5, lat);
    check("en_lat", lat, 8);
    check("en_w0", bus.w0_o, 90);

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
